decode_ctrl: RTL and testbench

//  Decode-stage sequencer between instruction fetch and execute. Accepts an instruction

---
 rtl/decode_ctrl.sv | 152 +++++++++++++++
 tb/tb_decode_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// Decode-stage sequencer: one-entry stage register between fetch and execute.
// Classifies the held word, forwards legal words and traps illegal opcodes.
module decode_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic [XLEN-1:0]  imm_instr,
    input  logic [XLEN-1:0]  imm_value,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_imm,
    output logic [2:0]       id_fmt,
    output logic [XLEN-1:0]  id_target,
    output logic             trap_valid,
    output logic [XLEN-1:0]  trap_instr,
    input  logic             trap_ack,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FULL,
        TRAP
    } state_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Opcode is a recognised base-ISA format
    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JALR, OP_LOAD, OP_IMM,
            OP_STORE, OP_BRANCH, OP_JAL, OP_REG: is_legal = 1'b1;
            default:                             is_legal = 1'b0;
        endcase
    endfunction

    // Format code of an opcode; unrecognised opcodes read as R
    function automatic logic [2:0] fmt_of(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC:         fmt_of = FMT_U;
            OP_JALR, OP_LOAD, OP_IMM: fmt_of = FMT_I;
            OP_STORE:                 fmt_of = FMT_S;
            OP_BRANCH:                fmt_of = FMT_B;
            OP_JAL:                   fmt_of = FMT_J;
            default:                  fmt_of = FMT_R;
        endcase
    endfunction

    state_t            state;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   pc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              id_valid_q;
    logic              trap_valid_q;
    logic              accept;
    logic              take_imm;
    logic [2:0]        fmt;

    assign if_ready = !flush
                   && ((state == IDLE) || ((state == FULL) && id_ready));
    assign accept   = if_valid && if_ready;

    assign fmt      = fmt_of(instr_q[6:0]);
    assign take_imm = (fmt == FMT_B) || (fmt == FMT_J)
                   || (instr_q[6:0] == OP_AUIPC);

    assign imm_instr   = instr_q;
    assign id_instr    = instr_q;
    assign id_pc       = pc_q;
    assign id_fmt      = fmt;
    assign trap_instr  = instr_q;
    assign id_valid    = id_valid_q;
    assign trap_valid  = trap_valid_q;
    assign illegal_cnt = cnt_q;

    // Immediate and target derive from the held word; sum wraps at XLEN
    always_comb begin
        id_imm    = (fmt == FMT_R) ? '0 : imm_value;
        id_target = pc_q + (take_imm ? id_imm : XLEN'(4));
    end

    // Stage register, state machine and saturating illegal counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            id_valid_q   <= 1'b0;
            trap_valid_q <= 1'b0;
            instr_q      <= XLEN'(32'h0000_0013);
            pc_q         <= '0;
            cnt_q        <= '0;
        end else if (flush) begin
            state        <= IDLE;
            id_valid_q   <= 1'b0;
            trap_valid_q <= 1'b0;
        end else if (accept) begin
            instr_q <= if_instr;
            pc_q    <= if_pc;
            if (is_legal(if_instr[6:0])) begin
                state        <= FULL;
                id_valid_q   <= 1'b1;
                trap_valid_q <= 1'b0;
            end else begin
                state        <= TRAP;
                id_valid_q   <= 1'b0;
                trap_valid_q <= 1'b1;
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            case (state)
                FULL: begin
                    if (id_ready) begin
                        state      <= IDLE;
                        id_valid_q <= 1'b0;
                    end
                end
                TRAP: begin
                    if (trap_ack) begin
                        state        <= IDLE;
                        trap_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: directed words with hand-computed results,
// a monitor pops expectations whenever execute or trap handshakes complete.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] imm_instr;
    logic [31:0] imm_value;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic [2:0]  id_fmt;
    logic [31:0] id_target;
    logic        trap_valid;
    logic [31:0] trap_instr;
    logic        trap_ack;
    logic [7:0]  illegal_cnt;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        is_trap;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];

    decode_ctrl #(.XLEN(32), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .imm_instr   (imm_instr),
        .imm_value   (imm_value),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_imm      (id_imm),
        .id_fmt      (id_fmt),
        .id_target   (id_target),
        .trap_valid  (trap_valid),
        .trap_instr  (trap_instr),
        .trap_ack    (trap_ack),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    // External immediate generator; unknown opcodes decode as I-type
    function automatic logic [31:0] immgen(input logic [31:0] i);
        case (i[6:0])
            7'b0110111, 7'b0010111: immgen = {i[31:12], 12'b0};
            7'b0100011: immgen = {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: immgen = {{19{i[31]}}, i[31], i[7], i[30:25],
                                  i[11:8], 1'b0};
            7'b1101111: immgen = {{11{i[31]}}, i[31], i[19:12], i[20],
                                  i[30:21], 1'b0};
            default:    immgen = {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    always_comb imm_value = immgen(imm_instr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_id(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [2:0] f,
                           input logic [31:0] tgt);
        exp_t e;
        e.is_trap = 1'b0;
        e.instr   = ins;
        e.pc      = pc;
        e.imm     = imm;
        e.fmt     = f;
        e.target  = tgt;
        sb.push_back(e);
    endtask

    task automatic push_trap(input logic [31:0] ins);
        exp_t e;
        e.is_trap = 1'b1;
        e.instr   = ins;
        e.pc      = '0;
        e.imm     = '0;
        e.fmt     = '0;
        e.target  = '0;
        sb.push_back(e);
    endtask

    // Monitor: a handshake completing at the next edge consumes one entry
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (id_valid && id_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_id", id_instr, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("id_is_trap", 32'(e.is_trap), 32'd0);
                    chk("id_instr", id_instr, e.instr);
                    chk("id_pc", id_pc, e.pc);
                    chk("id_imm", id_imm, e.imm);
                    chk("id_fmt", 32'(id_fmt), 32'(e.fmt));
                    chk("id_target", id_target, e.target);
                end
            end
            if (trap_valid && trap_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_trap", trap_instr, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("trap_is_trap", 32'(e.is_trap), 32'd1);
                    chk("trap_instr", trap_instr, e.instr);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        id_ready = 1'b0;
        trap_ack = 1'b0;
        repeat (2) step();

        @(negedge clk);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_trap_valid", 32'(trap_valid), 32'd0);
        chk("rst_imm_instr", imm_instr, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        rst_n = 1'b1;

        // addi x1,x0,-1
        step();
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'hFFF0_0093;
        if_pc    = 32'h100;
        push_id(32'hFFF0_0093, 32'h100, 32'hFFFF_FFFF, 3'd1, 32'h104);
        step();
        if_valid = 1'b0;
        @(negedge clk);
        chk("addi_valid", 32'(id_valid), 32'd1);
        step();

        // beq -8 held under backpressure
        id_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'hFE00_0CE3;
        if_pc    = 32'h200;
        push_id(32'hFE00_0CE3, 32'h200, 32'hFFFF_FFF8, 3'd3, 32'h1F8);
        step();
        if_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("beq_hold_valid", 32'(id_valid), 32'd1);
            chk("beq_hold_ready", 32'(if_ready), 32'd0);
            chk("beq_hold_instr", id_instr, 32'hFE00_0CE3);
            chk("beq_hold_target", id_target, 32'h1F8);
            step();
        end
        id_ready = 1'b1;
        step();
        @(negedge clk);
        chk("beq_drained", 32'(id_valid), 32'd0);
        step();

        // Four back-to-back legal words
        if_valid = 1'b1;
        if_instr = 32'h1234_50B7;
        if_pc    = 32'h300;
        push_id(32'h1234_50B7, 32'h300, 32'h1234_5000, 3'd4, 32'h304);
        step();
        if_instr = 32'h0000_1117;
        if_pc    = 32'h304;
        push_id(32'h0000_1117, 32'h304, 32'h0000_1000, 3'd4, 32'h1304);
        step();
        if_instr = 32'h0011_2223;
        if_pc    = 32'h308;
        push_id(32'h0011_2223, 32'h308, 32'h4, 3'd2, 32'h30C);
        step();
        if_instr = 32'h0100_00EF;
        if_pc    = 32'h30C;
        push_id(32'h0100_00EF, 32'h30C, 32'h10, 3'd5, 32'h31C);
        step();
        if_valid = 1'b0;
        step();
        @(negedge clk);
        chk("b2b_drained", 32'(id_valid), 32'd0);
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
        step();

        // Illegal word trapped then acknowledged
        if_valid = 1'b1;
        if_instr = 32'hFFFF_FFFF;
        if_pc    = 32'h500;
        push_trap(32'hFFFF_FFFF);
        step();
        if_valid = 1'b0;
        @(negedge clk);
        chk("trap_valid", 32'(trap_valid), 32'd1);
        chk("trap_instr_held", trap_instr, 32'hFFFF_FFFF);
        chk("trap_if_ready", 32'(if_ready), 32'd0);
        chk("trap_no_id", 32'(id_valid), 32'd0);
        chk("trap_cnt", 32'(illegal_cnt), 32'd1);
        step();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        @(negedge clk);
        chk("ack_if_ready", 32'(if_ready), 32'd1);
        chk("ack_trap_clr", 32'(trap_valid), 32'd0);
        step();

        // R-format add held, then flushed while fetch offers a word
        id_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h0020_81B3;
        if_pc    = 32'h400;
        step();
        if_valid = 1'b0;
        @(negedge clk);
        chk("add_valid", 32'(id_valid), 32'd1);
        chk("add_imm_zero", id_imm, 32'h0);
        chk("add_fmt", 32'(id_fmt), 32'd0);
        chk("add_target", id_target, 32'h404);
        step();
        flush    = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h0010_0093;
        if_pc    = 32'h404;
        @(negedge clk);
        chk("flush_if_ready", 32'(if_ready), 32'd0);
        step();
        flush    = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        chk("flush_id_valid", 32'(id_valid), 32'd0);
        chk("flush_if_ready_after", 32'(if_ready), 32'd1);
        step();
        @(negedge clk);
        chk("flush_not_accepted", 32'(id_valid), 32'd0);
        step();

        // Trap dropped by flush is not re-signalled
        if_valid = 1'b1;
        if_instr = 32'h0000_0000;
        if_pc    = 32'h600;
        step();
        if_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        chk("ftrap_valid", 32'(trap_valid), 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("ftrap_dropped", 32'(trap_valid), 32'd0);
        chk("ftrap_cnt", 32'(illegal_cnt), 32'd2);
        step();

        // 256 more illegal words: counter saturates at 255
        for (int i = 0; i < 256; i++) begin
            if_valid = 1'b1;
            if_instr = 32'hFF00_007F | (32'(i) << 8);
            push_trap(32'hFF00_007F | (32'(i) << 8));
            step();
            if_valid = 1'b0;
            trap_ack = 1'b1;
            step();
            trap_ack = 1'b0;
            if (i == 251) chk("sat_cnt_254", 32'(illegal_cnt), 32'd254);
            if (i == 252) chk("sat_cnt_255", 32'(illegal_cnt), 32'd255);
        end
        chk("sat_cnt_hold", 32'(illegal_cnt), 32'd255);

        // Reset while a word is held discards it
        id_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'hFFF0_0093;
        if_pc    = 32'h700;
        step();
        if_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_id_valid", 32'(id_valid), 32'd0);
        chk("mid_rst_instr", imm_instr, 32'h0000_0013);
        chk("mid_rst_cnt", 32'(illegal_cnt), 32'd0);
        id_ready = 1'b1;
        step();
        @(negedge clk);
        chk("mid_rst_quiet", 32'(id_valid), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
